// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST controller.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int NUM_CASES = 4;

    localparam logic [3:0] TRUTH_NOR  = 4'b0001;
    localparam logic [3:0] TRUTH_AND  = 4'b1000;
    localparam logic [3:0] TRUTH_OR   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR  = 4'b0110;
    localparam logic [3:0] TRUTH_NAND = 4'b0111;

    // The timer is loaded with (cycles - 1), so it only has to hold max-1.
    function automatic int cnt_width(input int unsigned settle, input int unsigned gap);
        int unsigned m;
        m = (settle > gap) ? settle : gap;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/gate_bist_if.sv
// Stimulus/result bundle between the BIST controller and the gate plus its supervisor.
interface gate_bist_if;

    logic       start;
    logic       gate_out;
    logic       gate_a;
    logic       gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_id;
    logic [3:0] fail_mask;

    modport master (
        input  start, gate_out,
        output gate_a, gate_b, busy, done, pass, fail_id, fail_mask
    );

    modport slave (
        output start, gate_out,
        input  gate_a, gate_b, busy, done, pass, fail_id, fail_mask
    );

endinterface

// File: rtl/gate_bist_timer.sv
// Loadable down-counter with a zero flag; shared by the settle and gap phases.
module gate_bist_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller: walks a 2-input gate through 00,01,10,11 and checks against TRUTH.
// GATE_BIST_CONTINUE_EN: when defined, mismatches do not stop the run.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   SETTLE | vector applied, waiting SETTLE_CYCLES
//   CHECK  | one-cycle compare of gate_out against TRUTH
//   GAP    | idle GAP_CYCLES before the next vector
//   DONE   | results valid, waiting for start
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 5,
    parameter int unsigned GAP_CYCLES    = 5,
    parameter logic [3:0]  TRUTH         = TRUTH_NOR
) (
    input logic         clk,
    input logic         rst_n,
    gate_bist_if.master bus
);

`ifdef GATE_BIST_CONTINUE_EN
    localparam bit STOP_ON_FAIL = 1'b0;
`else
    localparam bit STOP_ON_FAIL = 1'b1;
`endif

    localparam int CW = cnt_width(SETTLE_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD    = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    vec_q, vec_d;
    logic [3:0]    fail_mask_q;
    logic [2:0]    fail_id_q;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;
    logic          clr_results;
    logic          record;
    logic          mismatch;
    logic          last_case;

    gate_bist_timer #(.WIDTH(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

    assign last_case = (vec_q == 2'(NUM_CASES - 1));

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        tmr_load    = 1'b0;
        tmr_val     = SETTLE_LOAD;
        clr_results = 1'b0;
        record      = 1'b0;
        // Written as if/else so an unknown gate_out lands on the mismatch branch.
        if (bus.gate_out == TRUTH[vec_q]) mismatch = 1'b0;
        else                              mismatch = 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d     = ST_SETTLE;
                    vec_d       = 2'b00;
                    tmr_load    = 1'b1;
                    tmr_val     = SETTLE_LOAD;
                    clr_results = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                record = mismatch;
                if (mismatch && STOP_ON_FAIL) begin
                    state_d = ST_DONE;
                    vec_d   = 2'b00;
                end else if (GAP_CYCLES != 0) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end else if (last_case) begin
                    state_d = ST_DONE;
                    vec_d   = 2'b00;
                end else begin
                    state_d  = ST_SETTLE;
                    vec_d    = vec_q + 2'd1;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    if (last_case) begin
                        state_d = ST_DONE;
                        vec_d   = 2'b00;
                    end else begin
                        state_d  = ST_SETTLE;
                        vec_d    = vec_q + 2'd1;
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_mask_q <= 4'b0000;
            fail_id_q   <= 3'd0;
        end else if (clr_results) begin
            fail_mask_q <= 4'b0000;
            fail_id_q   <= 3'd0;
        end else if (record) begin
            fail_mask_q[vec_q] <= 1'b1;
            if (fail_id_q == 3'd0) fail_id_q <= {1'b0, vec_q} + 3'd1;
        end
    end

    assign bus.gate_a    = vec_q[1];
    assign bus.gate_b    = vec_q[0];
    assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK) || (state_q == ST_GAP);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = (state_q == ST_DONE) && (fail_mask_q == 4'b0000);
    assign bus.fail_id   = fail_id_q;
    assign bus.fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: timeline model compared every cycle plus literal pins.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

`ifdef GATE_BIST_CONTINUE_EN
    localparam bit         STOP        = 1'b0;
    localparam int         STUCK_DT    = 44;
    localparam logic [3:0] STUCK_MASK  = 4'b1110;
    localparam bit         STUCK_SEEN3 = 1'b1;
`else
    localparam bit         STOP        = 1'b1;
    localparam int         STUCK_DT    = 17;
    localparam logic [3:0] STUCK_MASK  = 4'b0010;
    localparam bit         STUCK_SEEN3 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    bit   stuck;
    int   n_cmp, n_bad;
    int   cyc = 0;

    bit         run0, run1;
    int         t00, t01;
    logic [3:0] fails0, fails1;

    gate_bist_if bus0();
    gate_bist_if bus1();

    always #5 clk = ~clk;

    assign bus0.gate_out = stuck ? 1'b1 : ~(bus0.gate_a | bus0.gate_b);
    assign bus1.gate_out = bus1.gate_a ^ bus1.gate_b;

    gate_bist_ctrl dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    gate_bist_ctrl #(.SETTLE_CYCLES(1), .GAP_CYCLES(0), .TRUTH(TRUTH_XOR)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    // Which cases the attached gate gets wrong relative to the expected table.
    function automatic logic [3:0] fails_of(input bit is_xor, input bit stk, input logic [3:0] truth);
        logic [3:0] f;
        logic [1:0] kv;
        logic       g;
        f = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            kv = 2'(k);
            g  = stk ? 1'b1 : (is_xor ? (kv[1] ^ kv[0]) : ~(kv[1] | kv[0]));
            f[k] = (g != truth[k]);
        end
        return f;
    endfunction

    function automatic int run_len(input int s, input int g, input logic [3:0] f);
        int p, dc;
        p  = s + 1 + g;
        dc = 4 * p;
        if (STOP) for (int k = 3; k >= 0; k--) if (f[k]) dc = k * p + s + 1;
        return dc;
    endfunction

    // Packed expectation {a,b,busy,done,pass,fail_id,fail_mask} n edges after the start edge.
    function automatic logic [11:0] model_out(input bit run, input int n, input int s, input int g,
                                              input logic [3:0] f);
        int         p, dc, lim;
        logic [3:0] mask;
        logic [2:0] id;
        logic [1:0] v;
        logic       bz, dn, ps;
        if (!run) return 12'd0;
        p    = s + 1 + g;
        dc   = run_len(s, g, f);
        lim  = (n < dc) ? n : dc;
        mask = 4'b0000;
        id   = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (f[k] && (k * p + s + 1) <= lim) begin
                mask[k] = 1'b1;
                if (id == 3'd0) id = 3'(k + 1);
            end
        end
        if (n < dc) begin
            v = 2'(n / p); bz = 1'b1; dn = 1'b0; ps = 1'b0;
        end else begin
            v = 2'b00; bz = 1'b0; dn = 1'b1; ps = (mask == 4'b0000);
        end
        return {v, bz, dn, ps, id, mask};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run0 <= 1'b0;
            run1 <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (bus0.start && (!run0 || (cyc - t00) >= run_len(5, 5, fails0))) begin
                run0   <= 1'b1;
                t00    <= cyc + 1;
                fails0 <= fails_of(1'b0, stuck, TRUTH_NOR);
            end
            if (bus1.start && (!run1 || (cyc - t01) >= run_len(1, 0, fails1))) begin
                run1   <= 1'b1;
                t01    <= cyc + 1;
                fails1 <= fails_of(1'b1, 1'b0, TRUTH_XOR);
            end
        end
    end

    function automatic logic [11:0] pack0();
        return {bus0.gate_a, bus0.gate_b, bus0.busy, bus0.done, bus0.pass, bus0.fail_id, bus0.fail_mask};
    endfunction

    function automatic logic [11:0] pack1();
        return {bus1.gate_a, bus1.gate_b, bus1.busy, bus1.done, bus1.pass, bus1.fail_id, bus1.fail_mask};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic pulse(input bit which, output int t);
        if (which) bus1.start = 1'b1; else bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        t = cyc;
    endtask

    task automatic wait_done(input bit which, input int t0, output int dt, output bit seen3);
        int i;
        i     = 0;
        seen3 = 1'b0;
        while (!(which ? bus1.done : bus0.done) && i < 200) begin
            if (!which && bus0.gate_a && !bus0.gate_b) seen3 = 1'b1;
            @(negedge clk);
            i++;
        end
        if (!(which ? bus1.done : bus0.done)) check("done_timeout", 0, 1);
        dt = cyc - t0;
    endtask

    initial begin
        int  t, dt;
        bit  s3;
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        stuck      = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        fork
            forever begin
                logic [11:0] e0, e1, g0, g1;
                @(negedge clk);
                e0 = model_out(run0, cyc - t00, 5, 5, fails0);
                e1 = model_out(run1, cyc - t01, 1, 0, fails1);
                g0 = pack0();
                g1 = pack1();
                n_cmp++;
                if (g0 !== e0) begin
                    n_bad++;
                    $display("FAIL cycle_dut0 at cyc %0d: got %h, required %h", cyc, g0, e0);
                end
                n_cmp++;
                if (g1 !== e1) begin
                    n_bad++;
                    $display("FAIL cycle_dut1 at cyc %0d: got %h, required %h", cyc, g1, e1);
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_outputs", int'(pack0()), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good NOR, with an ignored start at cycle 10 of the run.
        pulse(1'b0, t);
        repeat (9) @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_done(1'b0, t, dt, s3);
        check("good_done_cycle", dt, 44);
        check("good_pass", int'(bus0.pass), 1);
        check("good_fail_id", int'(bus0.fail_id), 0);
        check("good_fail_mask", int'(bus0.fail_mask), 0);

        // Output stuck at 1, restarted from DONE.
        repeat (5) @(negedge clk);
        stuck = 1'b1;
        pulse(1'b0, t);
        wait_done(1'b0, t, dt, s3);
        check("stuck_done_cycle", dt, STUCK_DT);
        check("stuck_pass", int'(bus0.pass), 0);
        check("stuck_fail_id", int'(bus0.fail_id), 2);
        check("stuck_fail_mask", int'(bus0.fail_mask), int'(STUCK_MASK));
        check("stuck_case3_applied", int'(s3), int'(STUCK_SEEN3));

        // Restart clears results; reset at cycle 20 aborts the run.
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        pulse(1'b0, t);
        check("restart_done_clear", int'(bus0.done), 0);
        check("restart_mask_clear", int'(bus0.fail_mask), 0);
        check("restart_id_clear", int'(bus0.fail_id), 0);
        while (cyc < t + 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", int'(pack0()), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(1'b0, t);
        wait_done(1'b0, t, dt, s3);
        check("post_reset_done_cycle", dt, 44);
        check("post_reset_pass", int'(bus0.pass), 1);
        check("post_reset_fail_id", int'(bus0.fail_id), 0);
        check("post_reset_fail_mask", int'(bus0.fail_mask), 0);

        // XOR configuration, no gap, one settle cycle.
        @(negedge clk);
        pulse(1'b1, t);
        wait_done(1'b1, t, dt, s3);
        check("xor_done_cycle", dt, 8);
        check("xor_pass", int'(bus1.pass), 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Synthesizable built-in self-test controller for a 2-input combinational gate. It drives the gate's inputs through all four input combinations, waits a programmable settle time, compares the gate output against a parameterized truth table, and reports pass/fail with the first failing case number. It sits beside a gate instance (e.g. `nor_gate`) as the on-chip stimulus/checker end of the gate's `a`/`b`/`out` interface.

## Interface
- `SETTLE_CYCLES`, 5, cycles a vector is held before sampling `gate_out`; legal range ≥1.
- `GAP_CYCLES`, 5, idle cycles after each check before the next vector; legal range ≥0.
- `TRUTH`, 4'b0001, expected output indexed by `{a,b}`; the default is NOR.
- `clk`  in  1  Sole clock; all state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Begin a test run; sampled only in IDLE or DONE.
- `gate_out`  in  1  Output of the gate under test.
- `gate_a`  out  1  Gate input a; registered.
- `gate_b`  out  1  Gate input b; registered.
- `busy`  out  1  High from the first vector until the run ends.
- `done`  out  1  Level; high from run end until the next accepted `start` or reset.
- `pass`  out  1  Valid while `done` is high; 1 means no mismatch.
- `fail_id`  out  3  Number (1–4) of the first failing case; 0 if pass.
- `fail_mask`  out  4  Bit k-1 is set if case k failed.

## Operation
- Case k (1..4) applies `{gate_a,gate_b}` = k-1, in the order 00, 01, 10, 11. The expected output is `TRUTH[{gate_a,gate_b}]`.
- FSM states:
  - IDLE: `start`=1 loads case 1 and goes to SETTLE.
  - SETTLE: counts `SETTLE_CYCLES`, then goes to CHECK.
  - CHECK: one cycle; `gate_out` is compared and a mismatch is recorded at the end of the cycle. Then GAP, or DONE after the last case (see Configuration).
  - GAP: counts `GAP_CYCLES`; with 0 it is skipped. It then loads the next vector and goes to SETTLE, or goes to DONE after case 4.
  - DONE: `done`=1 and `busy`=0. `start` clears the results and restarts at case 1.
- An X or Z value on `gate_out` counts as a mismatch in simulation.
- `start` in SETTLE, CHECK or GAP is ignored.
- `pass` = (`fail_mask` == 0).
- `fail_id` is written once, on the first mismatch of a run.
- Reset values: `gate_a`=0, `gate_b`=0, `busy`=0, `done`=0, `pass`=0, `fail_id`=0, `fail_mask`=0, state IDLE.
- Reset asserted mid-run aborts the run immediately (asynchronously), with no partial results retained.
- In IDLE and DONE, `gate_a`/`gate_b` = 00.

## Timing
- `start` is high at edge t0. The case-1 vector and `busy`=1 are visible after t0.
- Each case occupies `SETTLE_CYCLES` + 1 + `GAP_CYCLES` cycles. The vector changes on the edge ending the last GAP cycle.
- Full run: `done` rises 4·(`SETTLE_CYCLES`+1+`GAP_CYCLES`) cycles after t0, which is 44 cycles at the defaults. `busy` falls on the same edge.
- Early stop: `done` rises on the edge ending the failing CHECK cycle.
- `pass`, `fail_id` and `fail_mask` are stable whenever `done`=1.

## Configuration
- `GATE_BIST_CONTINUE_EN` defined:
  - A mismatch does not stop the run; all four cases always execute.
  - `fail_mask` accumulates every failing case.
- `GATE_BIST_CONTINUE_EN` undefined (default):
  - The first mismatch ends the run: CHECK goes directly to DONE and the remaining cases are skipped.
  - `fail_mask` has exactly one bit set when failing.

## Structure
- `gate_bist_pkg` holds:
  - the state enum (IDLE, SETTLE, CHECK, GAP, DONE);
  - `NUM_CASES`=4;
  - truth-table constants: `TRUTH_NOR`=4'b0001, `TRUTH_AND`=4'b1000, `TRUTH_OR`=4'b1110, `TRUTH_XOR`=4'b0110, `TRUTH_NAND`=4'b0111;
  - counter width derived from max(`SETTLE_CYCLES`, `GAP_CYCLES`).
- One sub-module, `gate_bist_timer`: a loadable down-counter with a `zero` flag. It is shared by SETTLE and GAP.

## Test plan
- Correct NOR connected, defaults, `start` pulse → `done` 44 cycles later; `pass`=1, `fail_id`=0, `fail_mask`=0000. Vectors seen in order 00, 01, 10, 11, each held 11 cycles.
- `gate_out` stuck at 1, macro undefined → `done` at cycle 17 (6+5+6); `pass`=0, `fail_id`=2, `fail_mask`=0010; case 3 is never applied.
- `gate_out` stuck at 1, `GATE_BIST_CONTINUE_EN` defined → `done` at cycle 44; `fail_id`=2, `fail_mask`=1110.
- `start` pulsed at cycle 10 of a run → ignored, `done` still at cycle 44. `start` pulsed in DONE → results cleared, new run begins.
- `rst_n` low at cycle 20 → all outputs return to their reset values immediately. `start` after release → full run from case 1 with a clean result.
- `GAP_CYCLES`=0, `SETTLE_CYCLES`=1, `TRUTH`=`TRUTH_XOR` with an XOR model → `done` 8 cycles after `start`; `pass`=1.
